// File: rtl/time_report_pkg.sv
// time_report_pkg: shared state encoding and ASCII constants for the time report serializer.
package time_report_pkg;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;
    localparam int MSG_LEN = 7;
    localparam logic [7:0] DIGIT_BASE = 8'h30;
    localparam logic [7:0] DASH       = 8'h2D;
    localparam logic [7:0] CR         = 8'h0D;
    localparam logic [7:0] LF         = 8'h0A;
endpackage

// File: rtl/bin_to_ascii2.sv
// bin_to_ascii2: 6-bit value to two ASCII digits, or "--" when the value exceeds MAX.
module bin_to_ascii2 import time_report_pkg::*; #(
    parameter logic [5:0] MAX = 6'd59
) (
    input  logic [5:0] value,
    output logic [7:0] tens_char,
    output logic [7:0] ones_char
);
    logic [2:0] tens;
    logic [3:0] ones;
    always_comb begin
        tens = value >= 6'd60 ? 3'd6 : value >= 6'd50 ? 3'd5 : value >= 6'd40 ? 3'd4 :
               value >= 6'd30 ? 3'd3 : value >= 6'd20 ? 3'd2 : value >= 6'd10 ? 3'd1 : 3'd0;
        ones = 4'(value - 6'(tens) * 6'd10);
        tens_char = value > MAX ? DASH : DIGIT_BASE + {5'd0, tens};
        ones_char = value > MAX ? DASH : DIGIT_BASE + {4'd0, ones};
    end
endmodule

// File: rtl/time_report_tx.sv
// time_report_tx: sends "HH:MM\r\n" to UartTx one byte per start/ready handshake.
// Define AUTO_REPORT_EN to also start a report on every minutes change.
module time_report_tx import time_report_pkg::*; #(
    parameter int         ReadyTimeout = 16,
    parameter logic [7:0] Separator    = 8'h3A
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       request,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic       uartReady,
    output logic       startTransmission,
    output logic [7:0] dataBits,
    output logic       busy,
    output logic       done,
    output logic       timeoutError
);
    localparam int CW = $clog2(ReadyTimeout + 1);
    state_t state_q, state_d;
    logic [2:0] index_q, index_d;
    logic [CW-1:0] count_q, count_d;
    logic [5:0] hours_q, hours_d, minutes_q, minutes_d;
    logic start_d, busy_d, done_d, error_d;
    logic [7:0] data_d, h_tens, h_ones, m_tens, m_ones, msg_byte;
    logic trigger;
    bin_to_ascii2 #(.MAX(6'd23)) u_hours (.value(hours_q), .tens_char(h_tens), .ones_char(h_ones));
    bin_to_ascii2 #(.MAX(6'd59)) u_minutes (.value(minutes_q), .tens_char(m_tens), .ones_char(m_ones));
    always_comb
        msg_byte = index_q == 3'd0 ? h_tens : index_q == 3'd1 ? h_ones : index_q == 3'd2 ? Separator :
                   index_q == 3'd3 ? m_tens : index_q == 3'd4 ? m_ones : index_q == 3'd5 ? CR : LF;
`ifdef AUTO_REPORT_EN
    // primed_q suppresses a spurious report from the reset value of the history register
    logic [5:0] min_prev_q;
    logic pending_q, pending_d, primed_q, changed;
    always_comb begin
        changed = primed_q && (minutes != min_prev_q);
        trigger = request || pending_q || changed;
        pending_d = state_q == IDLE ? 1'b0 : pending_q || changed;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            min_prev_q <= '0;
            pending_q  <= 1'b0;
            primed_q   <= 1'b0;
        end else begin
            min_prev_q <= minutes;
            pending_q  <= pending_d;
            primed_q   <= 1'b1;
        end
    end
`else
    always_comb trigger = request;
`endif
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        count_d   = count_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        start_d   = 1'b0;
        data_d    = dataBits;
        busy_d    = busy;
        done_d    = 1'b0;
        error_d   = timeoutError;
        case (state_q)
            IDLE: if (trigger) begin
                hours_d   = hours;
                minutes_d = minutes;
                index_d   = '0;
                busy_d    = 1'b1;
                error_d   = 1'b0;
                state_d   = SEND;
            end
            SEND: if (uartReady) begin
                data_d  = msg_byte;
                start_d = 1'b1;
                count_d = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: if (!uartReady) begin
                state_d = WAIT_DONE;
            end else if (count_q == CW'(ReadyTimeout - 1)) begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end else begin
                count_d = count_q + 1'b1;
            end
            WAIT_DONE: if (uartReady) begin
                if (index_q == 3'(MSG_LEN - 1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    index_d = index_q + 3'd1;
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q           <= IDLE;
            index_q           <= '0;
            count_q           <= '0;
            hours_q           <= '0;
            minutes_q         <= '0;
            startTransmission <= 1'b0;
            dataBits          <= 8'h00;
            busy              <= 1'b0;
            done              <= 1'b0;
            timeoutError      <= 1'b0;
        end else begin
            state_q           <= state_d;
            index_q           <= index_d;
            count_q           <= count_d;
            hours_q           <= hours_d;
            minutes_q         <= minutes_d;
            startTransmission <= start_d;
            dataBits          <= data_d;
            busy              <= busy_d;
            done              <= done_d;
            timeoutError      <= error_d;
        end
    end
endmodule

// File: tb/tb_time_report_tx.sv
// tb_time_report_tx: scoreboard bench with a UartTx model driving uartReady.
module tb_time_report_tx;
    logic clock = 1'b0, reset = 1'b0, request = 1'b0, uartReady = 1'b1;
    logic [5:0] hours = '0, minutes = '0;
    logic startTransmission, busy, done, timeoutError;
    logic [7:0] dataBits;
    int checks = 0, passed = 0;
    logic [7:0] exp_q[$];
    int low_cycles = 20, rx_count = 0, done_count = 0, reset_epoch = 0, rx_epoch;
    bit stuck = 1'b0;
    logic [7:0] rx_b, rx_want;

    time_report_tx dut (
        .clock(clock), .reset(reset), .request(request), .hours(hours), .minutes(minutes),
        .uartReady(uartReady), .startTransmission(startTransmission), .dataBits(dataBits),
        .busy(busy), .done(done), .timeoutError(timeoutError)
    );

    always #5 clock = ~clock;

    // UartTx model: takes the byte on a start pulse, holds ready low for low_cycles
    initial forever begin
        @(negedge clock);
        if (startTransmission === 1'b1 && !stuck) begin
            rx_b = dataBits;
            rx_epoch = reset_epoch;
            rx_count++;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL rx_byte: got %h, no byte expected", rx_b);
            end else begin
                rx_want = exp_q.pop_front();
                if (rx_b !== rx_want) $display("FAIL rx_byte: got %h, want %h", rx_b, rx_want);
                else passed++;
            end
            uartReady = 1'b0;
            repeat (low_cycles) @(negedge clock);
            if (rx_epoch == reset_epoch) begin
                checks++;
                if (dataBits !== rx_b) $display("FAIL data_hold: got %h, want %h", dataBits, rx_b);
                else passed++;
            end
            uartReady = 1'b1;
        end
    end

    always @(negedge clock) if (done === 1'b1) begin
        done_count++;
        checks++;
        if (busy !== 1'b0) $display("FAIL done_busy: busy=%b with done, want 0", busy);
        else passed++;
    end

    function automatic logic [7:0] dig(input logic [5:0] v, input int mx, input bit tens);
        if (int'(v) > mx) return 8'h2D;
        return tens ? 8'h30 + 8'(v / 10) : 8'h30 + 8'(v % 10);
    endfunction

    task automatic push_msg(input logic [5:0] h, input logic [5:0] m);
        exp_q.push_back(dig(h, 23, 1));
        exp_q.push_back(dig(h, 23, 0));
        exp_q.push_back(8'h3A);
        exp_q.push_back(dig(m, 59, 1));
        exp_q.push_back(dig(m, 59, 0));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic pulse_request(input bit chk);
        @(negedge clock);
        request = 1'b1;
        @(negedge clock);
        if (chk) begin
            checks++;
            if (busy !== 1'b1 || timeoutError !== 1'b0)
                $display("FAIL accept: busy=%b err=%b, want busy=1 err=0", busy, timeoutError);
            else passed++;
        end
        request = 1'b0;
    endtask

    task automatic wait_rx(input int target);
        for (int i = 0; i < 3000 && rx_count < target; i++) @(negedge clock);
        checks++;
        if (rx_count < target) $display("FAIL wait_rx: got %0d bytes, want %0d", rx_count, target);
        else passed++;
    endtask

    task automatic wait_msg(input int target);
        for (int i = 0; i < 6000 && !(done_count >= target && busy === 1'b0 && uartReady === 1'b1); i++)
            @(negedge clock);
        checks++;
        if (done_count < target) $display("FAIL wait_msg: got %0d done, want %0d", done_count, target);
        else passed++;
    endtask

    task automatic check_after(input string name, input int r0, input int d0, input int nmsg);
        repeat (30) @(negedge clock);
        checks++;
        if (rx_count - r0 !== 7 * nmsg || done_count - d0 !== nmsg || exp_q.size() !== 0 || timeoutError !== 1'b0)
            $display("FAIL %s: bytes=%0d done=%0d left=%0d err=%b, want bytes=%0d done=%0d left=0 err=0",
                     name, rx_count - r0, done_count - d0, exp_q.size(), timeoutError, 7 * nmsg, nmsg);
        else passed++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({startTransmission, dataBits, busy, done, timeoutError} !== 12'h000)
            $display("FAIL reset_vals: got %b, want 0", {startTransmission, dataBits, busy, done, timeoutError});
        else passed++;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({startTransmission, busy, done, timeoutError} !== 4'b0000)
            $display("FAIL idle_vals: got %b, want 0000", {startTransmission, busy, done, timeoutError});
        else passed++;
    endtask

    task automatic test_message(input logic [5:0] h, input logic [5:0] m, input int low, input bit first_pulse);
        int r0, d0;
        r0 = rx_count;
        d0 = done_count;
        low_cycles = low;
        @(negedge clock);
        hours = h;
        minutes = m;
        push_msg(h, m);
        pulse_request(1'b1);
        if (first_pulse) begin
            @(negedge clock);
            checks++;
            if (startTransmission !== 1'b1) $display("FAIL first_start: got %b, want 1", startTransmission);
            else passed++;
        end
        wait_msg(d0 + 1);
        check_after("message", r0, d0, 1);
    endtask

    task automatic test_mid_change();
        int r0, d0, n;
        r0 = rx_count;
        d0 = done_count;
        n = 1;
        low_cycles = 20;
        @(negedge clock);
        hours = 13;
        minutes = 7;
        push_msg(13, 7);
`ifdef AUTO_REPORT_EN
        push_msg(13, 8);
        n = 2;
`endif
        pulse_request(1'b1);
        wait_rx(r0 + 2);
        minutes = 8;
        pulse_request(1'b0);
        wait_msg(d0 + n);
        check_after("mid_change", r0, d0, n);
    endtask

    task automatic test_timeout();
        int d0, n;
        d0 = done_count;
        stuck = 1'b1;
        pulse_request(1'b1);
        n = 0;
        for (int i = 0; i < 20 && startTransmission !== 1'b1; i++) @(negedge clock);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (timeoutError === 1'b1) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n !== 16) $display("FAIL timeout_cycles: got %0d, want 16", n);
        else passed++;
        checks++;
        if (busy !== 1'b0 || done_count !== d0)
            $display("FAIL timeout_state: busy=%b done=%0d, want busy=0 done=0", busy, done_count - d0);
        else passed++;
        stuck = 1'b0;
        test_message(9, 30, 20, 1'b0);
    endtask

    task automatic test_reset_mid();
        int r0;
        r0 = rx_count;
        low_cycles = 20;
        @(negedge clock);
        hours = 13;
        minutes = 7;
        push_msg(13, 7);
        pulse_request(1'b1);
        wait_rx(r0 + 4);
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({startTransmission, dataBits, busy, done} !== 11'h000)
            $display("FAIL async_reset: got %b, want 0", {startTransmission, dataBits, busy, done});
        else passed++;
        exp_q.delete();
        reset_epoch++;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 200 && uartReady !== 1'b1; i++) @(negedge clock);
        test_message(13, 7, 20, 1'b0);
    endtask

`ifdef AUTO_REPORT_EN
    task automatic test_auto();
        int r0, d0;
        @(negedge clock);
        hours = 10;
        minutes = 5;
        repeat (40) @(negedge clock);
        r0 = rx_count;
        d0 = done_count;
        push_msg(10, 6);
        push_msg(10, 7);
        minutes = 6;
        wait_rx(r0 + 2);
        minutes = 7;
        wait_msg(d0 + 2);
        check_after("auto", r0, d0, 2);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_message(13, 7, 100, 1'b1);
        test_message(0, 0, 20, 1'b0);
        test_message(23, 59, 20, 1'b0);
        test_message(24, 60, 20, 1'b0);
        test_mid_change();
        test_timeout();
        test_reset_mid();
`ifdef AUTO_REPORT_EN
        test_auto();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/time_report_tx.md
# time_report_tx

Serializes the current time of day (hours, minutes) into the 7-byte ASCII message "HH:MM\r\n" and feeds it byte by byte into the UartTx transmitter through its startTransmission/dataBits/ready handshake. The block sits between TimeOfDay (source of minutes/hours) and UartTx (consumer), replacing the switch-driven dataBits/KEY-driven start on the top level. A report is triggered by a request pulse and, optionally, automatically on every minute change.

## Interface
- ReadyTimeout, 16: max clock cycles to wait for uartReady to drop after a start pulse before aborting.
- Separator, 8'h3A: byte emitted between hours and minutes (':').
- clock  input  1  system clock (CLOCK_24[0] on the top level).
- reset  input  1  asynchronous, active-low reset (top connects KEY[0] directly).
- request  input  1  level-sampled report request; accepted only in IDLE.
- hours  input  6  hours from TimeOfDay, valid range 0..23.
- minutes  input  6  minutes from TimeOfDay, valid range 0..59.
- uartReady  input  1  UartTx ready (high = idle, able to accept a byte).
- startTransmission  output  1  one-cycle start pulse to UartTx.
- dataBits  output  8  byte to UartTx; stable from start pulse until uartReady returns high.
- busy  output  1  high while a report is in progress.
- done  output  1  one-cycle pulse after the 7th byte completed.
- timeoutError  output  1  sticky; set on ReadyTimeout abort, cleared by reset or next accepted request.

## Operation
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: on request=1, capture hours/minutes into snapshot registers, index<=0, busy<=1, timeoutError<=0, go SEND. Later input changes do not affect the message in flight.
- SEND: when uartReady=1, drive dataBits<=byte[index], startTransmission<=1 for exactly one cycle, clear timeout counter, go WAIT_BUSY. If uartReady=0, stay.
- WAIT_BUSY: on uartReady=0 go WAIT_DONE. Counter increments each cycle; reaching ReadyTimeout -> timeoutError<=1, busy<=0, go IDLE (no done pulse).
- WAIT_DONE: on uartReady=1: if index==6 -> done<=1, busy<=0, go IDLE; else index<=index+1, go SEND.
- Message bytes: 0 hours tens, 1 hours ones, 2 Separator, 3 minutes tens, 4 minutes ones, 5 8'h0D, 6 8'h0A.
- Digit conversion: tens = value/10 via compare chain (value 0..63 -> tens 0..6), ones = value - 10*tens; ASCII = 8'h30 + digit.
- Out of range: hours>23 -> bytes 0,1 are "--" (8'h2D); minutes>59 -> bytes 3,4 are "--".
- request while busy: ignored, not queued (except as below with AUTO_REPORT_EN).

## Timing
- Reset values: startTransmission=0, dataBits=8'h00, busy=0, done=0, timeoutError=0, state IDLE, index 0.
- All outputs registered. request high at edge N -> busy=1 after N; first start pulse at edge N+1 at the earliest (uartReady already high).
- Minimum per-byte overhead: 2 cycles beyond UartTx's own frame time (SEND + WAIT_DONE exit).
- done and busy falling occur on the same edge.
- Reset mid-report: outputs return to reset values immediately (asynchronous); a byte already started in UartTx completes on its own; no resume.

## Configuration
- AUTO_REPORT_EN defined: block keeps a registered copy of minutes; any change of minutes sets a pending flag. In IDLE, pending or request starts a report and clears pending. Change while busy sets pending, served directly after return to IDLE. Simultaneous request and pending -> one report.
- Not defined: only request starts a report; no minutes history register, no pending flag.

## Structure
- Package time_report_pkg: state enum, message length constant (7), ASCII constants (digit base 8'h30, dash 8'h2D, CR 8'h0D, LF 8'h0A).
- Sub-module bin_to_ascii2: combinational 6-bit value + max limit -> two ASCII bytes (digits or "--"); instantiated twice (hours max 23, minutes max 59).

## Test plan
- hours=13, minutes=7, request pulse, UART model ready-low 100 cycles per byte -> bytes 31 33 3A 30 37 0D 0A in order, one done pulse, timeoutError=0.
- hours=0, minutes=0 -> "00:00\r\n"; hours=23, minutes=59 -> "23:59\r\n"; hours=24, minutes=60 -> "--:--\r\n".
- Change minutes 7->8 in mid report -> message still carries "07"; request pulse during busy -> no second message.
- UART model never drops ready after start -> timeoutError=1 after 16 cycles, busy=0, no done; next request clears timeoutError and sends.
- Assert reset during byte 3 -> startTransmission, busy, done, dataBits at 0 at once; following request sends full 7-byte message from byte 0.
- AUTO_REPORT_EN: minutes 5->6 with no request -> one report "HH:06"; change during report -> exactly one further report immediately after done.
